npn_canon: RTL

Sequential NPN canonicalizer for 4-input Boolean functions. It accepts a 16-bit truth table and scans all 24 input permutations × 16 input-negation masks, with both output polarities, one (permutation, mask) pair per cycle. It returns the numerically smallest transformed table plus the transform that produced it. It is the inverse companion of the per-class exact-synthesis netlists: it maps an arbitrary function onto the NPN class representative that selects the netlist.

---
 rtl/npn_pkg.sv | 42 ++++
 rtl/npn_canon_if.sv | 26 ++
 rtl/npn_apply.sv | 31 +++
 rtl/npn_canon.sv | 121 ++++++++++++
 4 files changed

// File: rtl/npn_pkg.sv
// Shared constants, FSM states and permutation table for the
// 4-input NPN canonicalizer.
package npn_pkg;

    localparam int N_PERM = 24;
    localparam int N_NEG  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Entry [2i+1:2i] holds p(i); rows in lexicographic order of (p0,p1,p2,p3)
    localparam logic [7:0] PERM_LUT [N_PERM] = '{
        {2'd3, 2'd2, 2'd1, 2'd0},
        {2'd2, 2'd3, 2'd1, 2'd0},
        {2'd3, 2'd1, 2'd2, 2'd0},
        {2'd1, 2'd3, 2'd2, 2'd0},
        {2'd2, 2'd1, 2'd3, 2'd0},
        {2'd1, 2'd2, 2'd3, 2'd0},
        {2'd3, 2'd2, 2'd0, 2'd1},
        {2'd2, 2'd3, 2'd0, 2'd1},
        {2'd3, 2'd0, 2'd2, 2'd1},
        {2'd0, 2'd3, 2'd2, 2'd1},
        {2'd2, 2'd0, 2'd3, 2'd1},
        {2'd0, 2'd2, 2'd3, 2'd1},
        {2'd3, 2'd1, 2'd0, 2'd2},
        {2'd1, 2'd3, 2'd0, 2'd2},
        {2'd3, 2'd0, 2'd1, 2'd2},
        {2'd0, 2'd3, 2'd1, 2'd2},
        {2'd1, 2'd0, 2'd3, 2'd2},
        {2'd0, 2'd1, 2'd3, 2'd2},
        {2'd2, 2'd1, 2'd0, 2'd3},
        {2'd1, 2'd2, 2'd0, 2'd3},
        {2'd2, 2'd0, 2'd1, 2'd3},
        {2'd0, 2'd2, 2'd1, 2'd3},
        {2'd1, 2'd0, 2'd2, 2'd3},
        {2'd0, 2'd1, 2'd2, 2'd3}
    };

endpackage

// File: rtl/npn_canon_if.sv
// Input and result handshake bundle for npn_canon.
interface npn_canon_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_tt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_tt;
    logic [4:0]  out_perm;
    logic [3:0]  out_neg;
    logic        out_onot;

    modport master (
        output in_valid, in_tt, out_ready,
        input  in_ready, out_valid, out_tt,
        input  out_perm, out_neg, out_onot
    );

    modport slave (
        input  in_valid, in_tt, out_ready,
        output in_ready, out_valid, out_tt,
        output out_perm, out_neg, out_onot
    );

endinterface

// File: rtl/npn_apply.sv
// Combinational input permute/negate of a 4-input truth table:
// t[k] = tt[z], z_i = k_{p(i)} ^ n_i.
module npn_apply
    import npn_pkg::*;
(
    input  logic [15:0] i_tt,
    input  logic [4:0]  i_perm,
    input  logic [3:0]  i_neg,
    output logic [15:0] o_t
);

    logic [7:0] w_p;

    assign w_p = (i_perm < 5'(N_PERM)) ? PERM_LUT[i_perm] : PERM_LUT[0];

    always_comb begin
        logic [3:0] w_kv;
        logic [3:0] w_z;
        o_t  = '0;
        w_kv = '0;
        w_z  = '0;
        for (int k = 0; k < 16; k++) begin
            w_kv = 4'(k);
            for (int i = 0; i < 4; i++) begin
                w_z[i] = w_kv[w_p[2*i +: 2]] ^ i_neg[i];
            end
            o_t[k] = i_tt[w_z];
        end
    end

endmodule

// File: rtl/npn_canon.sv
// Sequential NPN canonicalizer: scans 24 permutations x 16 negation
// masks, one per cycle, keeping the smallest output-normalized table.
module npn_canon
    import npn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    npn_canon_if.slave  bus
);

    state_t      r_state;
    logic [15:0] r_f;
    logic [4:0]  r_perm;
    logic [3:0]  r_neg;
    logic        r_fin;
    logic [15:0] r_best;
    logic [4:0]  r_bperm;
    logic [3:0]  r_bneg;
    logic        r_bo;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [15:0] r_out_tt;
    logic [4:0]  r_out_perm;
    logic [3:0]  r_out_neg;
    logic        r_out_onot;

    logic [15:0] w_t;
    logic [15:0] w_c;
    logic        w_o;
    logic        w_better;

    npn_apply u_apply (
        .i_tt   (r_f),
        .i_perm (r_perm),
        .i_neg  (r_neg),
        .o_t    (w_t)
    );

    // ~t < t exactly when the MSB of t is set
    assign w_o      = w_t[15];
    assign w_c      = w_o ? ~w_t : w_t;
    assign w_better = (w_c < r_best);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_f         <= '0;
            r_perm      <= '0;
            r_neg       <= '0;
            r_fin       <= 1'b0;
            r_best      <= 16'hFFFF;
            r_bperm     <= '0;
            r_bneg      <= '0;
            r_bo        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_tt    <= '0;
            r_out_perm  <= '0;
            r_out_neg   <= '0;
            r_out_onot  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_f        <= bus.in_tt;
                        r_best     <= 16'hFFFF;
                        r_bperm    <= '0;
                        r_bneg     <= '0;
                        r_bo       <= 1'b0;
                        r_perm     <= '0;
                        r_neg      <= '0;
                        r_fin      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_fin) begin
                        r_out_valid <= 1'b1;
                        r_out_tt    <= r_best;
                        r_out_perm  <= r_bperm;
                        r_out_neg   <= r_bneg;
                        r_out_onot  <= r_bo;
                        r_state     <= DONE;
                    end else begin
                        if (w_better) begin
                            r_best  <= w_c;
                            r_bperm <= r_perm;
                            r_bneg  <= r_neg;
                            r_bo    <= w_o;
                        end
                        if (r_neg != 4'(N_NEG - 1)) begin
                            r_neg <= r_neg + 4'd1;
                        end else if (r_perm != 5'(N_PERM - 1)) begin
                            r_neg  <= '0;
                            r_perm <= r_perm + 5'd1;
                        end else begin
                            r_fin <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_tt    = r_out_tt;
    assign bus.out_perm  = r_out_perm;
    assign bus.out_neg   = r_out_neg;
    assign bus.out_onot  = r_out_onot;

endmodule
